// File: rtl/text_console_buffer_pkg.sv
// ---------------------------------------------------------------------------
// vga_text_pkg
// Shared definitions for the text console buffer that feeds the VGA text
// renderer: screen geometry, the ASCII control codes the console reacts to,
// the console FSM state type, the character class type produced by the
// classifier, and a small helper that locates a column inside a packed row.
// ---------------------------------------------------------------------------
package vga_text_pkg;

   // Default screen geometry; one row maps onto one renderer txtN input.
   localparam int TXT_ROWS = 20;
   localparam int TXT_COLS = 32;

   // Control codes and the blank fill character.
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_SP = 8'h20;

   // Printable range written straight into the screen.
   localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
   localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {
      IDLE,
      SCROLL,
      CLEAR
   } console_state_t;

   typedef enum logic [2:0] {
      CC_PRINT,
      CC_LF,
      CC_CR,
      CC_BS,
      CC_OTHER
   } char_class_t;

   typedef logic [TXT_COLS*8-1:0] txt_row_t;

   // Bit offset of the least significant bit of column col in a packed row
   // of cols characters. Column 0 occupies the most significant byte so the
   // row reads left-to-right like a string literal.
   function automatic int col_lsb(input int cols, input int col);
      return (cols - 1 - col) * 8;
   endfunction

endpackage

// File: rtl/text_console_buffer_char_class.sv
// ---------------------------------------------------------------------------
// console_char_class
// Purely combinational classifier for the incoming console byte.
//   char_in     in   8   ASCII byte presented on the console input
//   char_class  out      PRINT (0x20..0x7E), LF, CR, BS or OTHER
// ---------------------------------------------------------------------------
module console_char_class
   import vga_text_pkg::*;
(
   input  logic [7:0]  char_in,
   output char_class_t char_class
);

   always_comb begin
      // NOTE: a default assignment at the top of a combinational block makes
      // every path drive the output, so no latch can be inferred.
      char_class = CC_OTHER;
      if (char_in >= ASCII_PRINT_LO && char_in <= ASCII_PRINT_HI) begin
         char_class = CC_PRINT;
      end else begin
         case (char_in)
            ASCII_LF: char_class = CC_LF;
            ASCII_CR: char_class = CC_CR;
            ASCII_BS: char_class = CC_BS;
            default:  char_class = CC_OTHER;
         endcase
      end
   end

endmodule

// File: rtl/text_console_buffer.sv
// ---------------------------------------------------------------------------
// text_console_buffer
// Accepts an ASCII byte stream over a valid/ready handshake and maintains a
// ROWS x COLS character screen with a cursor, for the VGA text renderer.
// Handles printable characters with line wrap, LF, CR, BS, scrolling and a
// row-by-row screen clear.
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   char_in     in   ASCII byte
//   char_valid  in   char_in is valid
//   char_ready  out  a byte can be accepted this cycle
//   clear       in   single-cycle request to blank the screen, home cursor
//   busy        out  high while clearing or scrolling
//   cursor_row  out  current cursor row
//   cursor_col  out  current cursor column
//   row_txt     out  one packed row per screen line, column 0 in the MSB byte
// ---------------------------------------------------------------------------
module text_console_buffer
   import vga_text_pkg::*;
#(
   parameter int         ROWS  = TXT_ROWS,
   parameter int         COLS  = TXT_COLS,
   parameter logic [7:0] BLANK = ASCII_SP
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [7:0]                       char_in,
   input  logic                             char_valid,
   output logic                             char_ready,
   input  logic                             clear,
   output logic                             busy,
   output logic [$clog2(ROWS)-1:0]          cursor_row,
   output logic [$clog2(COLS)-1:0]          cursor_col,
   output logic [ROWS-1:0][COLS*8-1:0]      row_txt
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

   localparam logic [COLS*8-1:0] BLANK_ROW = {COLS{BLANK}};

   console_state_t  state;
   logic [RW-1:0]   clear_row;
   char_class_t     char_class;
   logic            accept;

   console_char_class u_char_class (
      .char_in    (char_in),
      .char_class (char_class)
   );

   // Ready only in IDLE with no competing clear request; held low during
   // reset so an upstream source never sees a handshake it cannot complete.
   assign char_ready = !rst && (state == IDLE) && !clear;
   assign accept     = char_valid && char_ready;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the screen registers are reset explicitly because the
         // renderer displays them directly; unknown contents would be visible.
         row_txt    <= {(ROWS*COLS){BLANK}};
         state      <= IDLE;
         clear_row  <= '0;
         cursor_row <= '0;
         cursor_col <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the pre-edge value of the others (the scroll shift relies on it).
         case (state)
            IDLE: begin
               if (clear) begin
                  // clear wins over a simultaneous byte; char_ready is low.
                  state     <= CLEAR;
                  clear_row <= '0;
               end else if (accept) begin
                  case (char_class)
                     CC_PRINT: begin
                        row_txt[cursor_row][col_lsb(COLS, int'(cursor_col)) +: 8] <= char_in;
                        if (cursor_col != LAST_COL) begin
                           cursor_col <= cursor_col + 1'b1;
                        end else begin
                           // Wrap. On the last row the byte has already
                           // landed; the scroll moves it up one line.
                           cursor_col <= '0;
                           if (cursor_row == LAST_ROW) begin
                              state <= SCROLL;
                           end else begin
                              cursor_row <= cursor_row + 1'b1;
                           end
                        end
                     end
                     CC_LF: begin
                        cursor_col <= '0;
                        if (cursor_row == LAST_ROW) begin
                           state <= SCROLL;
                        end else begin
                           cursor_row <= cursor_row + 1'b1;
                        end
                     end
                     CC_CR: begin
                        cursor_col <= '0;
                     end
                     CC_BS: begin
                        // No reverse wrap: backspace at column 0 is a no-op.
                        if (cursor_col != '0) begin
                           cursor_col <= cursor_col - 1'b1;
                           row_txt[cursor_row][col_lsb(COLS, int'(cursor_col) - 1) +: 8] <= BLANK;
                        end
                     end
                     default: begin
                        // Unsupported byte: consumed without effect.
                     end
                  endcase
               end
            end

            SCROLL: begin
               // Single-cycle shift of every row up by one line.
               for (int r = 0; r < ROWS - 1; r++) begin
                  row_txt[r] <= row_txt[r+1];
               end
               row_txt[ROWS-1] <= BLANK_ROW;
               cursor_row      <= LAST_ROW;
               cursor_col      <= '0;
               state           <= IDLE;
            end

            CLEAR: begin
               // One row per cycle; a clear request arriving now is ignored.
               row_txt[clear_row] <= BLANK_ROW;
               if (clear_row == LAST_ROW) begin
                  cursor_row <= '0;
                  cursor_col <= '0;
                  state      <= IDLE;
               end else begin
                  clear_row <= clear_row + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_buffer.sv
// ---------------------------------------------------------------------------
// tb_text_console_buffer
// Self-checking bench for text_console_buffer. A character-array model of
// the screen and cursor predicts every row and the cursor position.
// ---------------------------------------------------------------------------
module tb_text_console_buffer;
   import vga_text_pkg::*;

   localparam int ROWS = 20;
   localparam int COLS = 32;
   localparam logic [7:0] SP = 8'h20;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [7:0]                   char_in;
   logic                         char_valid;
   logic                         char_ready;
   logic                         clear;
   logic                         busy;
   logic [4:0]                   cursor_row;
   logic [4:0]                   cursor_col;
   logic [ROWS-1:0][COLS*8-1:0]  row_txt;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference screen: plain character grid and cursor.
   byte unsigned scr [ROWS][COLS];
   int           m_row;
   int           m_col;

   always #5 clk = ~clk;

   text_console_buffer #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .BLANK (SP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .clear      (clear),
      .busy       (busy),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .row_txt    (row_txt)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void m_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            scr[r][c] = SP;
      m_row = 0;
      m_col = 0;
   endfunction

   function automatic void m_scroll();
      for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r+1];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = SP;
      m_row = ROWS - 1;
      m_col = 0;
   endfunction

   function automatic void m_newline();
      m_col = 0;
      if (m_row == ROWS - 1) m_scroll();
      else m_row++;
   endfunction

   function automatic void m_put(input byte unsigned b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         scr[m_row][m_col] = b;
         if (m_col == COLS - 1) m_newline();
         else m_col++;
      end else if (b == 8'h0A) begin
         m_newline();
      end else if (b == 8'h0D) begin
         m_col = 0;
      end else if (b == 8'h08) begin
         if (m_col > 0) begin
            m_col--;
            scr[m_row][m_col] = SP;
         end
      end
   endfunction

   function automatic logic [255:0] m_row_bits(input int r);
      logic [255:0] v;
      v = '0;
      for (int c = 0; c < COLS; c++) v[(COLS-c)*8-1 -: 8] = scr[r][c];
      return v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic check_cursor(input string tag);
      check({tag, " cursor_row"}, cursor_row, m_row);
      check({tag, " cursor_col"}, cursor_col, m_col);
   endtask

   task automatic check_screen(input string tag);
      for (int r = 0; r < ROWS; r++)
         check($sformatf("%s row%0d", tag, r), row_txt[r], m_row_bits(r));
      check_cursor(tag);
   endtask

   task automatic send(input byte unsigned b);
      int t;
      t = 0;
      @(negedge clk);
      while (!char_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!char_ready) begin
         n_checks++;
         n_fail++;
         $error("FAIL ready_timeout: observed char_ready %0b expected 1", char_ready);
      end
      char_in    = b;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      m_put(b);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $error("FAIL idle_timeout: observed busy %0b expected 0", busy);
      end
   endtask

   // Clear pulsed together with a valid byte; counts busy cycles.
   task automatic do_clear(input string tag);
      int cnt;
      wait_idle();
      clear      = 1'b1;
      char_valid = 1'b1;
      char_in    = 8'h51;
      #1;
      check({tag, " ready_during_clear_req"}, char_ready, 1'b0);
      @(posedge clk);
      #1;
      clear      = 1'b0;
      char_valid = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (busy && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, cnt, ROWS);
      m_clear();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [255:0] exp_row;
      logic [255:0] saved_row1;
      byte unsigned b;
      int k;

      rst        = 1'b1;
      char_in    = 8'h00;
      char_valid = 1'b0;
      clear      = 1'b0;
      m_clear();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst ready_low", char_ready, 1'b0);
      check("rst busy_low", busy, 1'b0);
      rst = 1'b0;
      #1;
      check("post_rst ready", char_ready, 1'b1);
      check_screen("reset");

      // "HI"
      send_str("HI");
      wait_idle();
      exp_row = {8'h48, 8'h49, {30{8'h20}}};
      check("hi row0", row_txt[0], exp_row);
      check("hi cursor_row", cursor_row, 0);
      check("hi cursor_col", cursor_col, 2);
      check_screen("hi");

      // Clear with a simultaneous byte
      do_clear("clear1");
      check_screen("clear1");

      // 33 x 'A' wraps onto row 1
      for (int i = 0; i < 33; i++) send(8'h41);
      wait_idle();
      exp_row = {32{8'h41}};
      check("wrap row0", row_txt[0], exp_row);
      check("wrap row1 col0", row_txt[1][255:248], 8'h41);
      check("wrap row1 col1", row_txt[1][247:240], 8'h20);
      check("wrap cursor_row", cursor_row, 1);
      check("wrap cursor_col", cursor_col, 1);

      // Backspace at column 0 and mid-row
      do_clear("clear2");
      send_str("\n\n\n");
      wait_idle();
      send(8'h08);
      wait_idle();
      check("bs_col0 cursor_row", cursor_row, 3);
      check("bs_col0 cursor_col", cursor_col, 0);
      check_screen("bs_col0");
      send_str("abcd");
      send(8'h08);
      wait_idle();
      check("bs row3 col3", row_txt[3][(COLS-3)*8-1 -: 8], 8'h20);
      check("bs row3 col2", row_txt[3][(COLS-2)*8-1 -: 8], 8'h63);
      check("bs cursor_row", cursor_row, 3);
      check("bs cursor_col", cursor_col, 3);
      // CR returns to column 0 without moving the row
      send(8'h0D);
      wait_idle();
      check_screen("cr");

      // Scroll from (19,5) on LF
      do_clear("clear3");
      send(8'h0A);
      send_str("ROW1 text");
      for (int i = 0; i < 18; i++) send(8'h0A);
      send_str("12345");
      wait_idle();
      check("pre_scroll cursor_row", cursor_row, 19);
      check("pre_scroll cursor_col", cursor_col, 5);
      saved_row1 = m_row_bits(1);
      @(negedge clk);
      char_in    = 8'h0A;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      m_put(8'h0A);
      @(negedge clk);
      check("scroll ready_low", char_ready, 1'b0);
      check("scroll busy_high", busy, 1'b1);
      @(negedge clk);
      check("scroll ready_back", char_ready, 1'b1);
      check("scroll row0_is_old_row1", row_txt[0], saved_row1);
      check("scroll row19_blank", row_txt[19], {32{8'h20}});
      check("scroll cursor_row", cursor_row, 19);
      check("scroll cursor_col", cursor_col, 0);
      check_screen("scroll");

      // Printable wrap at the last row also scrolls
      for (int i = 0; i < 32; i++) send(8'h30 + 8'(i % 10));
      wait_idle();
      check_screen("wrap_scroll");

      // Randomized stream against the model
      do_clear("clear4");
      for (int n = 0; n < 700; n++) begin
         k = $urandom_range(0, 99);
         if (k < 78)      b = 8'($urandom_range(32, 126));
         else if (k < 86) b = 8'h0A;
         else if (k < 90) b = 8'h0D;
         else if (k < 97) b = 8'h08;
         else             b = 8'($urandom_range(128, 255));
         send(b);
         wait_idle();
         check_cursor($sformatf("rand%0d", n));
         if (n % 100 == 99) check_screen($sformatf("rand%0d", n));
      end

      // Reset in the middle of a clear
      wait_idle();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("midclear busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      #1;
      m_clear();
      check("midclear busy", busy, 1'b0);
      check("midclear ready", char_ready, 1'b0);
      check_screen("midclear");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midclear ready_after", char_ready, 1'b1);
      send_str("OK");
      wait_idle();
      check_screen("after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
